// File: rtl/ifetch_pkg.sv
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                reset PC default, fetch state encoding, FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // One buffered instruction: fetch address in the upper half, word below.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fifo_entry_t;

  // Instructions are 32-bit; any address with low bits set is misaligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_if.sv
// ============================================================================
//  Module      : ifetch_if
//  Description : Bundles the instruction-memory request/response channel and
//                the decode-side valid/ready channel of the fetch unit.
//                master = fetch unit view, slave = memory/decode view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ============================================================================
//  Module      : ifetch_fifo
//  Description : Synchronous DEPTH-entry FIFO of {pc, inst} entries with
//                clear, full/empty flags and an occupancy count. Pointers
//                carry one extra wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic                     clear_i,
  input  wire fifo_entry_t              din_i,
  output fifo_entry_t                   dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  fifo_entry_t mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer and storage update; clear drops everything in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction fetch front end. Issues imem requests at the
//                current PC, tracks in-flight addresses, buffers returned
//                words and hands {inst, pc} to decode. Handles flush with
//                discard of stale responses and a sticky misalignment fault.
//                Optional macro IFETCH_PERF_EN enables the perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH           = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] pc_in,
  output logic             pc_ena,
  input  wire logic        flush,
  ifetch_if.master         bus,
  output logic             fetch_fault,
  output logic [31:0]      fault_pc,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int AQW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  fetch_state_e   state_q, state_d;
  logic [31:0]    fault_pc_q, fault_pc_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic [OW-1:0]  discard_q, discard_d;
  logic [31:0]    aq_mem_q [MAX_OUTSTANDING];
  logic [AQW-1:0] aq_wr_q, aq_rd_q;

  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  fifo_entry_t    fifo_din, fifo_dout;

  logic slot_free, pc_aligned, req_valid, fire, rsp, drop, push, pop, inst_valid;

  // Capacity counts both buffered words and words still owed by imem, so a
  // response can never find the FIFO full. Gated by reset so every request
  // output is low while rst_n is asserted.
  assign pc_aligned = is_aligned(pc_in);
  assign slot_free  = rst_n && (state_q == ST_RUN) && !flush
                      && ((int'(outstanding_q) + int'(fifo_count)) < DEPTH)
                      && (int'(outstanding_q) < MAX_OUTSTANDING);
  assign req_valid  = slot_free && pc_aligned;
  assign fire       = req_valid && bus.imem_req_ready;
  assign rsp        = bus.imem_rsp_valid;
  assign drop       = rsp && (discard_q != '0);
  assign push       = rsp && !drop && !flush && !fifo_full;
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && bus.inst_ready && !flush;

  assign pc_ena             = fire;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_in;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = fifo_dout.inst;
  assign bus.inst_pc        = fifo_dout.pc;
  assign fetch_fault        = (state_q == ST_FAULT);
  assign fault_pc           = fault_pc_q;

  assign fifo_din.pc   = aq_mem_q[aq_rd_q];
  assign fifo_din.inst = bus.imem_rsp_data;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control state: fault FSM, in-flight count and stale-response budget.
  always_comb begin
    state_d       = state_q;
    fault_pc_d    = fault_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    case (state_q)
      ST_RUN:   if (slot_free && !pc_aligned) begin
                  state_d    = ST_FAULT;
                  fault_pc_d = pc_in;
                end
      ST_FAULT: if (flush) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (fire && !rsp)      outstanding_d = outstanding_q + OW'(1);
    else if (!fire && rsp) outstanding_d = outstanding_q - OW'(1);
    // A response landing in the flush cycle is already stale, so it is
    // dropped here and not counted again.
    if (flush)     discard_d = rsp ? outstanding_q - OW'(1) : outstanding_q;
    else if (drop) discard_d = discard_q - OW'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fault_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fault_pc_q    <= fault_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Address queue: in-order responses consume the oldest issued address,
  // including responses that are being discarded after a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) aq_mem_q[i] <= '0;
    end else begin
      if (fire) begin
        aq_mem_q[aq_wr_q] <= pc_in;
        aq_wr_q <= (aq_wr_q == AQW'(MAX_OUTSTANDING - 1)) ? '0 : aq_wr_q + 1'b1;
      end
      if (rsp) aq_rd_q <= (aq_rd_q == AQW'(MAX_OUTSTANDING - 1)) ? '0 : aq_rd_q + 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Words accepted into the FIFO and cycles decode held off a valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push)                          perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_valid && !bus.inst_ready) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit. A queue-based model of
//                imem and of the expected delivery stream (epoch-tagged for
//                flush) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;
`ifdef IFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = RPC;
  logic        pc_ena, fetch_fault;
  logic [31:0] fault_pc, perf_fetched, perf_stall;

  ifetch_if bus();

  ifetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .pc_ena       (pc_ena),
    .flush        (flush),
    .bus          (bus),
    .fetch_fault  (fetch_fault),
    .fault_pc     (fault_pc),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        inflight[$];
  logic [31:0] buf_q[$];
  int          epoch, cyc, last_due, lat, n_fire, n_pop;
  bit          m_fault, have_last;
  logic [31:0] m_fault_pc, m_fetched, m_stall, pc_reg, last_pc;
  bit          k_ready, k_irdy, k_flush;
  logic [31:0] k_target;
  // per-cycle samples for directed checks
  bit          s_req, s_ena, s_ival, s_fault, s_popped;
  logic [31:0] s_addr, s_ipc, s_fpc, s_stall, s_pop_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive at negedge, check just before posedge, advance model.
  task automatic step();
    bit   exp_req, exp_ival, room, fire, rsp_now, pop;
    req_t r;
    int   due;
    @(negedge clk);
    pc_in              = pc_reg;
    flush              = k_flush;
    bus.imem_req_ready = k_ready;
    bus.inst_ready     = k_irdy;
    rsp_now            = (inflight.size() > 0) && (inflight[0].due <= cyc);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? word_of(inflight[0].addr) : 32'hDEAD_BEEF;
    #4;
    exp_ival = (buf_q.size() > 0);
    room     = !m_fault && !k_flush && (inflight.size() + buf_q.size() < DEPTH)
               && (inflight.size() < MAXO);
    exp_req  = room && (pc_in[1:0] == 2'b00);
    check("req_valid", bus.imem_req_valid, exp_req);
    check("pc_ena", pc_ena, exp_req && k_ready);
    check("imem_addr", bus.imem_addr, pc_reg);
    check("inst_valid", bus.inst_valid, exp_ival);
    if (exp_ival) begin
      check("inst_pc", bus.inst_pc, buf_q[0]);
      check("inst_data", bus.inst_data, word_of(buf_q[0]));
    end
    check("fetch_fault", fetch_fault, m_fault);
    check("fault_pc", fault_pc, m_fault_pc);
    check("perf_fetched", perf_fetched, PERF ? m_fetched : 32'h0);
    check("perf_stall", perf_stall, PERF ? m_stall : 32'h0);
    s_req = bus.imem_req_valid; s_ena = pc_ena; s_ival = bus.inst_valid;
    s_addr = bus.imem_addr; s_ipc = bus.inst_pc; s_fault = fetch_fault;
    s_fpc = fault_pc; s_stall = perf_stall; s_popped = 1'b0;

    fire = exp_req && k_ready;
    pop  = exp_ival && k_irdy && !k_flush;
    if (exp_ival && !k_irdy) m_stall++;
    if (pop) begin
      if (have_last) check("pc_seq", buf_q[0], last_pc + 32'd4);
      last_pc = buf_q[0]; have_last = 1'b1;
      s_popped = 1'b1; s_pop_pc = buf_q[0];
      void'(buf_q.pop_front());
      n_pop++;
    end
    if (k_flush) begin
      buf_q.delete();
      epoch++;
      have_last = 1'b0;
    end
    if (rsp_now) begin
      r = inflight.pop_front();
      if (r.epoch == epoch) begin
        buf_q.push_back(r.addr);
        m_fetched++;
      end
    end
    if (k_flush) m_fault = 1'b0;
    else if (!m_fault && room && pc_in[1:0] != 2'b00) begin
      m_fault    = 1'b1;
      m_fault_pc = pc_in;
    end
    if (fire) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      r.addr = pc_in; r.due = due; r.epoch = epoch;
      inflight.push_back(r);
      last_due = due;
      n_fire++;
      pc_reg = pc_reg + 32'd4;
    end
    if (k_flush) pc_reg = k_target;
    cyc++;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge.
  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0; bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    pc_in = start_pc;
    #1;
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_pc_ena", pc_ena, 1'b0);
    check("rst_fetch_fault", fetch_fault, 1'b0);
    check("rst_fault_pc", fault_pc, RPC);
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
    inflight.delete(); buf_q.delete();
    epoch = 0; cyc = 0; last_due = -1; n_fire = 0; n_pop = 0;
    m_fault = 1'b0; m_fault_pc = RPC; m_fetched = '0; m_stall = '0;
    have_last = 1'b0; pc_reg = start_pc;
    k_flush = 1'b0; k_target = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;

    // Basic fetch: request in cycle 0, word delivered in cycle 2.
    do_reset(RPC);
    k_ready = 1'b1; k_irdy = 1'b1; lat = 1;
    step();
    check("p1_req_c0", s_req, 1'b1);
    check("p1_ena_c0", s_ena, 1'b1);
    check("p1_addr_c0", s_addr, 32'h0040_0000);
    step();
    check("p1_addr_c1", s_addr, 32'h0040_0004);
    step();
    check("p1_ival_c2", s_ival, 1'b1);
    check("p1_ipc_c2", s_ipc, 32'h0040_0000);
    repeat (20) step();

    // Decode stall: only two requests fit, outputs held, stalls counted.
    do_reset(RPC);
    k_ready = 1'b1; k_irdy = 1'b0; lat = 1; stalls = 0;
    for (int i = 0; i < 40 && stalls < 10; i++) begin
      step();
      if (s_ival) stalls++;
    end
    check("p2_stall_cycles", stalls, 10);
    step();
    check("p2_fires", n_fire, 2);
    check("p2_req_idle", s_req, 1'b0);
    check("p2_perf_stall", s_stall, PERF ? 32'd10 : 32'd0);
    check("p2_full_pre_rst", s_ival, 1'b1);

    // Reset with a full FIFO, then flush with two requests outstanding.
    do_reset(RPC);
    k_ready = 1'b1; k_irdy = 1'b1; lat = 3;
    step(); step();
    k_flush = 1'b1; k_target = 32'h0040_0100;
    step();
    check("p3_req_in_flush", s_req, 1'b0);
    k_flush = 1'b0;
    for (int i = 0; i < 30 && !s_popped; i++) step();
    check("p3_popped", s_popped, 1'b1);
    check("p3_first_pc", s_pop_pc, 32'h0040_0100);
    repeat (10) step();

    // Misaligned PC raises the fault; flush clears it and fetching resumes.
    do_reset(32'h0040_0002);
    k_ready = 1'b1; k_irdy = 1'b1; lat = 1;
    step();
    check("p4_req", s_req, 1'b0);
    check("p4_ena", s_ena, 1'b0);
    step();
    check("p4_fault", s_fault, 1'b1);
    check("p4_fault_pc", s_fpc, 32'h0040_0002);
    k_flush = 1'b1; k_target = 32'h0040_0010;
    step();
    k_flush = 1'b0;
    step();
    check("p4_fault_clr", s_fault, 1'b0);
    check("p4_resume", s_req, 1'b1);
    check("p4_resume_addr", s_addr, 32'h0040_0010);
    repeat (10) step();

    // Random flow control with PC wrap-around, no flush.
    do_reset(32'hFFFF_FFE0);
    for (int i = 0; i < 10000; i++) begin
      k_ready = ($urandom_range(0, 3) != 0);
      k_irdy  = ($urandom_range(0, 2) != 0);
      lat     = $urandom_range(1, 4);
      step();
    end
    @(negedge clk); #4;
    check("p6_perf_fetched", perf_fetched, PERF ? n_pop + buf_q.size() : 0);
    check("p6_progress", n_pop > 1000, 1'b1);

    // Random flushes, occasionally to a misaligned target.
    do_reset(RPC);
    for (int i = 0; i < 2000; i++) begin
      k_ready  = ($urandom_range(0, 3) != 0);
      k_irdy   = ($urandom_range(0, 2) != 0);
      lat      = $urandom_range(1, 4);
      k_flush  = ($urandom_range(0, 49) == 0);
      k_target = {$urandom_range(0, 65535), 16'h0} |
                 (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
